// File: rtl/sram_dma.sv
// -----------------------------------------------------------------------------
// sram_dma
// Single-channel word-copy DMA engine. It acts as an ICB master placed directly
// upstream of the on-chip SRAM slave. A start pulse copies len_words 32-bit
// words from src_addr to dst_addr. Each word is moved with one read command,
// its response, and then one write command. Only one command is outstanding at
// any time.
//
// Ports
//   clk, rst_n          : clock; synchronous active-low reset
//   start               : one-cycle request, sampled only while idle
//   src_addr, dst_addr  : byte addresses; bits [1:0] are ignored
//   len_words           : number of words to copy (0 completes immediately)
//   busy                : high from the cycle after an accepted start until done
//   done                : one-cycle pulse on completion or abort
//   err                 : sticky abort flag, cleared by the next accepted start
//   m_icb_cmd_*         : ICB command channel (valid/ready/addr/read/wdata/wmask)
//   m_icb_rsp_*         : ICB read-response channel (valid/ready/err/rdata)
//
// Every output is a register. No combinational path runs from an ICB input to
// an ICB output.
// -----------------------------------------------------------------------------
module sram_dma #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             m_icb_cmd_valid,
   input  logic             m_icb_cmd_ready,
   output logic [31:0]      m_icb_cmd_addr,
   output logic             m_icb_cmd_read,
   output logic [31:0]      m_icb_cmd_wdata,
   output logic [3:0]       m_icb_cmd_wmask,
   input  logic             m_icb_rsp_valid,
   output logic             m_icb_rsp_ready,
   input  logic             m_icb_rsp_err,
   input  logic [31:0]      m_icb_rsp_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CMD,
      S_RD_RSP,
      S_WR_CMD,
      S_FIN
   } state_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_t           state;
   logic [31:0]      src_ptr;
   logic [31:0]      dst_ptr;
   logic [LEN_W-1:0] remain;

   // m_icb_cmd_wdata is the data register itself. The read data is latched
   // straight into it, so the write command needs no extra copy cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         src_ptr         <= '0;
         dst_ptr         <= '0;
         remain          <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         m_icb_cmd_valid <= 1'b0;
         m_icb_cmd_addr  <= '0;
         m_icb_cmd_read  <= 1'b0;
         m_icb_cmd_wdata <= '0;
         m_icb_cmd_wmask <= 4'h0;
         m_icb_rsp_ready <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  // Masking the whole word keeps all input bits in use while
                  // forcing word alignment.
                  src_ptr <= src_addr & WORD_MASK;
                  dst_ptr <= dst_addr & WORD_MASK;
                  remain  <= len_words;
                  err     <= 1'b0;
                  busy    <= 1'b1;
                  if (len_words == '0) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end else begin
                     state           <= S_RD_CMD;
                     m_icb_cmd_valid <= 1'b1;
                     m_icb_cmd_read  <= 1'b1;
                     m_icb_cmd_addr  <= src_addr & WORD_MASK;
                     m_icb_cmd_wmask <= 4'h0;
                  end
               end
            end

            S_RD_CMD: begin
               if (m_icb_cmd_ready) begin
                  state           <= S_RD_RSP;
                  m_icb_cmd_valid <= 1'b0;
                  m_icb_rsp_ready <= 1'b1;
               end
            end

            S_RD_RSP: begin
               if (m_icb_rsp_valid) begin
                  m_icb_rsp_ready <= 1'b0;
                  if (m_icb_rsp_err) begin
                     // Abort without writing the failed word.
                     err   <= 1'b1;
                     state <= S_FIN;
                     done  <= 1'b1;
                  end else begin
                     state           <= S_WR_CMD;
                     m_icb_cmd_wdata <= m_icb_rsp_rdata;
                     m_icb_cmd_valid <= 1'b1;
                     m_icb_cmd_read  <= 1'b0;
                     m_icb_cmd_addr  <= dst_ptr;
                     m_icb_cmd_wmask <= 4'hF;
                  end
               end
            end

            S_WR_CMD: begin
               // Writes produce no response, so the engine moves on as soon
               // as the slave accepts the write command.
               if (m_icb_cmd_ready) begin
                  src_ptr         <= src_ptr + 32'd4;
                  dst_ptr         <= dst_ptr + 32'd4;
                  remain          <= remain - LEN_W'(1);
                  m_icb_cmd_wmask <= 4'h0;
                  if (remain == LEN_W'(1)) begin
                     state           <= S_FIN;
                     done            <= 1'b1;
                     m_icb_cmd_valid <= 1'b0;
                  end else begin
                     state          <= S_RD_CMD;
                     m_icb_cmd_read <= 1'b1;
                     m_icb_cmd_addr <= src_ptr + 32'd4;
                  end
               end
            end

            S_FIN: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_dma.sv
// -----------------------------------------------------------------------------
// tb_sram_dma
// Scoreboard bench for sram_dma. Each start pushes the expected ICB command
// sequence and the expected completion record into queues. A behavioural copy
// model builds these from a snapshot of the SRAM model. A monitor process pops
// the queues and compares them whenever the DUT presents a command handshake
// or a done pulse. An SRAM slave model answers reads and absorbs writes. It can
// stall cmd_ready, delay responses, inject a read error, and drive stray
// rsp_valid while a write is pending.
// -----------------------------------------------------------------------------
module tb_sram_dma;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [LEN_W-1:0] len_words = '0;
   logic             busy, done, err;
   logic             cmd_valid, cmd_ready, cmd_read;
   logic [31:0]      cmd_addr, cmd_wdata;
   logic [3:0]       cmd_wmask;
   logic             rsp_valid, rsp_ready, rsp_err;
   logic [31:0]      rsp_rdata;

   sram_dma #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
      .busy(busy), .done(done), .err(err),
      .m_icb_cmd_valid(cmd_valid), .m_icb_cmd_ready(cmd_ready),
      .m_icb_cmd_addr(cmd_addr), .m_icb_cmd_read(cmd_read),
      .m_icb_cmd_wdata(cmd_wdata), .m_icb_cmd_wmask(cmd_wmask),
      .m_icb_rsp_valid(rsp_valid), .m_icb_rsp_ready(rsp_ready),
      .m_icb_rsp_err(rsp_err), .m_icb_rsp_rdata(rsp_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name, input logic [127:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%0h required=none", name, act);
   endtask

   // ---------------- scoreboard queues ----------------
   typedef struct packed {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } cmd_t;
   typedef struct {
      logic err;
      int   lat;
   } done_t;

   cmd_t  exp_cmd_q[$];
   done_t exp_done_q[$];
   int    start_cyc = 0;

   // ---------------- SRAM slave model ----------------
   logic [31:0] mem [logic [31:0]];
   int  err_idx = -1, stall_idx = -1, stall_left = 0, rd_cnt = 0;
   bit  rnd_mode = 1'b0;
   bit  pend_go = 1'b0, pend_err = 1'b0, rsp_real = 1'b0, rsp_taken = 1'b0;
   int  pend_wait = 0;
   logic [31:0] pend_data = '0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   initial begin
      cmd_ready = 1'b1;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && cmd_valid && cmd_ready) begin
            if (cmd_read) begin
               pend_data = mem.exists(cmd_addr) ? mem[cmd_addr] : dflt(cmd_addr);
               pend_err  = (rd_cnt == err_idx);
               if (pend_err) pend_data = $urandom;
               rd_cnt++;
               pend_wait = rnd_mode ? int'($urandom_range(1, 3)) : 1;
               pend_go   = 1'b1;
            end else begin
               mem[cmd_addr] = cmd_wdata;
            end
         end
         rsp_taken = rst_n && rsp_valid && rsp_ready && rsp_real;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pend_go   = 1'b0;
            rsp_real  = 1'b0;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            cmd_ready = 1'b1;
         end else begin
            if (rsp_taken) begin
               rsp_real  = 1'b0;
               rsp_valid = 1'b0;
               rsp_err   = 1'b0;
            end
            if (pend_go) begin
               pend_wait--;
               if (pend_wait == 0) begin
                  pend_go   = 1'b0;
                  rsp_real  = 1'b1;
                  rsp_valid = 1'b1;
                  rsp_err   = pend_err;
                  rsp_rdata = pend_data;
               end
            end
            if (!rsp_real) begin
               // Stray responses while a write is pending must be ignored.
               if (rnd_mode && cmd_valid && !cmd_read && $urandom_range(0, 1) == 1) begin
                  rsp_valid = 1'b1;
                  rsp_err   = 1'($urandom_range(0, 1));
                  rsp_rdata = $urandom;
               end else begin
                  rsp_valid = 1'b0;
                  rsp_err   = 1'b0;
               end
            end
            if (cmd_valid && cmd_read && rd_cnt == stall_idx && stall_left > 0) begin
               cmd_ready = 1'b0;
               stall_left--;
            end else if (rnd_mode) begin
               cmd_ready = ($urandom_range(0, 3) != 0);
            end else begin
               cmd_ready = 1'b1;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   bit          prev_stall = 1'b0;
   logic [72:0] prev_fields = '0;

   initial begin
      cmd_t  act;
      cmd_t  e;
      done_t d;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_stall)
               chk("cmd_hold", {cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask}, prev_fields);
            if (cmd_valid && cmd_ready) begin
               act = '{rd: cmd_read, addr: cmd_addr,
                       wdata: (cmd_read ? 32'h0 : cmd_wdata), wmask: cmd_wmask};
               if (exp_cmd_q.size() == 0) fail("cmd_unexpected", act);
               else begin
                  e = exp_cmd_q.pop_front();
                  chk("cmd", act, e);
               end
            end
            if (done) begin
               if (exp_done_q.size() == 0) fail("done_unexpected", {err});
               else begin
                  d = exp_done_q.pop_front();
                  chk("done_err", err, d.err);
                  if (d.lat >= 0) chk("done_latency", cyc - start_cyc + 1, d.lat);
               end
            end
            prev_stall  = cmd_valid && !cmd_ready;
            prev_fields = {cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask};
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // ---------------- reference model ----------------
   // Copies word by word over a snapshot of the SRAM, so overlapping blocks
   // see earlier writes, exactly as a sequential copier must.
   task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                             input int eidx, input int sidx, input int scyc, input bit lat_en);
      logic [31:0] m [logic [31:0]];
      logic [31:0] s, dd, v;
      int    nw = 0;
      int    nrd;
      bit    aborted = 1'b0;
      done_t rec;
      m  = mem;
      s  = {src[31:2], 2'b00};
      dd = {dst[31:2], 2'b00};
      for (int i = 0; i < len; i++) begin
         exp_cmd_q.push_back('{rd: 1'b1, addr: s, wdata: 32'h0, wmask: 4'h0});
         if (i == eidx) begin
            aborted = 1'b1;
            break;
         end
         v = m.exists(s) ? m[s] : dflt(s);
         m[dd] = v;
         exp_cmd_q.push_back('{rd: 1'b0, addr: dd, wdata: v, wmask: 4'hF});
         nw++;
         s  = s + 32'd4;
         dd = dd + 32'd4;
      end
      nrd = aborted ? nw + 1 : len;
      rec.err = aborted;
      rec.lat = -1;
      if (lat_en) begin
         rec.lat = aborted ? 3 * nw + 3 : 3 * len + 1;
         if (sidx >= 0 && sidx < nrd) rec.lat += scyc;
      end
      exp_done_q.push_back(rec);
   endtask

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int t = 0;
      while (busy && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (busy) fail("idle_timeout", busy);
   endtask

   task automatic kick(input logic [31:0] src, input logic [31:0] dst, input int len,
                       input int eidx, input int sidx, input int scyc, input bit rnd,
                       input bit lat_en);
      wait_idle();
      err_idx    = eidx;
      stall_idx  = sidx;
      stall_left = scyc;
      rnd_mode   = rnd;
      rd_cnt     = 0;
      model_copy(src, dst, len, eidx, sidx, scyc, lat_en);
      src_addr  = src;
      dst_addr  = dst;
      len_words = LEN_W'(len);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start     = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("err_cleared", err, 1'b0);
   endtask

   task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int eidx, input int sidx, input int scyc, input bit rnd,
                          input bit lat_en, input bit poke);
      bit saw_done = 1'b0;
      int t = 0;
      kick(src, dst, len, eidx, sidx, scyc, rnd, lat_en);
      while (!saw_done && t < 40 * len + 60) begin
         @(negedge clk);
         t++;
         if (done) begin
            saw_done = 1'b1;
            start    = 1'b0;
         end else if (poke) begin
            // Inputs must not be re-sampled mid-transfer; start must be ignored.
            src_addr  = $urandom;
            dst_addr  = $urandom;
            len_words = LEN_W'($urandom);
            start     = 1'($urandom_range(0, 1));
         end
      end
      start = 1'b0;
      if (!saw_done) fail("done_timeout", t);
      @(posedge clk);
      #1;
      chk("idle_after_done", busy, 1'b0);
      chk("cmds_consumed", exp_cmd_q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {busy, done, err, cmd_valid, cmd_read, rsp_ready, cmd_addr, cmd_wdata, cmd_wmask},
          '0);
   endtask

   initial begin
      logic [31:0] s, d;
      int n, ei;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset_outputs");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic 4-word copy with preloaded SRAM contents.
      for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * (i + 1);
      do_copy(32'h100, 32'h200, 4, -1, -1, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         chk("dst_word", mem.exists(32'h200 + 32'(4 * i)) ? mem[32'h200 + 32'(4 * i)] : 32'hDEAD,
             32'h1111_1111 * (i + 1));

      // Zero-length request: done after one cycle, no commands.
      do_copy(32'h100, 32'h200, 0, -1, -1, 0, 1'b0, 1'b1, 1'b0);

      // 5-cycle cmd_ready stall on the second read.
      do_copy(32'h100, 32'h500, 4, -1, 1, 5, 1'b0, 1'b1, 1'b0);

      // Read error on the third read of an 8-word copy, then a clean copy.
      do_copy(32'h100, 32'h600, 8, 2, -1, 0, 1'b0, 1'b1, 1'b0);
      chk("err_sticky", err, 1'b1);
      do_copy(32'h200, 32'h700, 2, -1, -1, 0, 1'b0, 1'b1, 1'b0);

      // Pointer wrap and unaligned source address.
      do_copy(32'hFFFF_FFF8, 32'h300, 3, -1, -1, 0, 1'b0, 1'b1, 1'b0);
      do_copy(32'h103, 32'h402, 2, -1, -1, 0, 1'b0, 1'b1, 1'b0);

      // Restart attempts while busy, then reset mid-transfer.
      kick(32'h100, 32'h800, 10, -1, -1, 0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b1;
         src_addr = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_outputs("midreset_outputs");
      exp_cmd_q.delete();
      exp_done_q.delete();
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_after_reset", {busy, done}, 2'b00);

      // Randomised copies with random stalls, delays and stray responses.
      for (int k = 0; k < 12; k++) begin
         s  = {22'h0, 10'($urandom_range(0, 1023))};
         d  = {22'h0, 10'($urandom_range(0, 1023))};
         n  = $urandom_range(1, 12);
         ei = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
         do_copy(s, d, n, ei, -1, 0, 1'b1, 1'b0, 1'b1);
      end

      rnd_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("final_queues_empty", {exp_cmd_q.size() == 0, exp_done_q.size() == 0}, 2'b11);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
